// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU command router and its interrupt controller.
package mcu_pkg;

    localparam logic [7:0] LOCAL_ID       = 8'h00;
    localparam logic [7:0] CMD_IRQ_STATUS = 8'h00;
    localparam logic [7:0] CMD_IRQ_MASK   = 8'h01;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCAL,
        ST_FWD_FIRST,
        ST_FWD,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/mcu_irq_ctrl.sv
// Interrupt mask, status snapshot, ack pulse generation and aggregated MCU irq.
module mcu_irq_ctrl #(
    parameter int unsigned NTGT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            status_rd,
    input  logic            mask_wr,
    input  logic [NTGT-1:0] mask_din,
    input  logic [NTGT-1:0] tgt_irq,
    output logic [NTGT-1:0] snapshot,
    output logic [NTGT-1:0] tgt_iack,
    output logic            mcu_irq
);

    logic [NTGT-1:0] irq_mask;
    logic [NTGT-1:0] pending_c;

    assign pending_c = tgt_irq & irq_mask;

    // Acks cover exactly the sources reported in the snapshot, so a later rise stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '1;
            snapshot <= '0;
            tgt_iack <= '0;
            mcu_irq  <= 1'b0;
        end else begin
            tgt_iack <= '0;
            mcu_irq  <= |pending_c;
            if (status_rd) begin
                snapshot <= pending_c;
                tgt_iack <= pending_c;
            end
            if (mask_wr) begin
                irq_mask <= mask_din;
            end
        end
    end

endmodule

// File: rtl/mcu_cmd_router.sv
// Routes MCU frames to peripheral targets by leading id byte, muxes replies back,
// and serves a local irq status/mask target.
module mcu_cmd_router
    import mcu_pkg::*;
#(
    parameter int unsigned NTGT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mcu_strobe,
    input  logic              mcu_start,
    input  logic [7:0]        mcu_din,
    output logic [7:0]        mcu_dout,
    output logic              mcu_irq,
    output logic [NTGT-1:0]   tgt_strobe,
    output logic              tgt_start,
    output logic [7:0]        tgt_din,
    input  logic [8*NTGT-1:0] tgt_dout,
    input  logic [NTGT-1:0]   tgt_irq,
    output logic [NTGT-1:0]   tgt_iack
);

    state_t           state;
    logic [7:0]       sel;
    logic [7:0]       cmd;
    logic [CNT_W-1:0] cnt;
    logic [NTGT-1:0]  snapshot;

    logic             frame_start_c;
    logic             data_strobe_c;
    logic             status_rd_c;
    logic             mask_wr_c;
    logic [NTGT-1:0]  sel_hot_c;
    logic [7:0]       fwd_reply_c;
    logic [7:0]       local_reply_c;

    assign frame_start_c = mcu_strobe & mcu_start;
    assign data_strobe_c = mcu_strobe & ~mcu_start;

    // Local command decode: byte 1 is the command, byte 2 carries mask data.
    assign status_rd_c = (state == ST_LOCAL) && data_strobe_c && (cnt == '0)
                         && (mcu_din == CMD_IRQ_STATUS);
    assign mask_wr_c   = (state == ST_LOCAL) && data_strobe_c && (cnt == CNT_W'(1))
                         && (cmd == CMD_IRQ_MASK);

    always_comb begin
        sel_hot_c   = '0;
        fwd_reply_c = 8'h00;
        for (int i = 0; i < NTGT; i++) begin
            if (sel == 8'(i + 1)) begin
                sel_hot_c[i] = 1'b1;
                fwd_reply_c  = tgt_dout[8*i +: 8];
            end
        end
    end

    assign local_reply_c = ((cnt != '0) && (cmd == CMD_IRQ_STATUS)) ? 8'(snapshot) : 8'h00;

    always_comb begin
        mcu_dout = 8'h00;
        case (state)
            ST_FWD_FIRST, ST_FWD: mcu_dout = fwd_reply_c;
            ST_LOCAL:             mcu_dout = local_reply_c;
            default:              mcu_dout = 8'h00;
        endcase
    end

    // Frame FSM; a frame start in any state aborts the current frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel        <= 8'h00;
            cmd        <= 8'h00;
            cnt        <= '0;
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            tgt_din    <= 8'h00;
        end else begin
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            if (frame_start_c) begin
                sel <= mcu_din;
                cnt <= '0;
                cmd <= 8'h00;
                if (mcu_din == LOCAL_ID) begin
                    state <= ST_LOCAL;
                end else if (mcu_din <= 8'(NTGT)) begin
                    state <= ST_FWD_FIRST;
                end else begin
                    state <= ST_DISCARD;
                end
            end else if (data_strobe_c) begin
                case (state)
                    ST_FWD_FIRST: begin
                        tgt_din    <= mcu_din;
                        tgt_start  <= 1'b1;
                        tgt_strobe <= sel_hot_c;
                        state      <= ST_FWD;
                    end
                    ST_FWD: begin
                        tgt_din    <= mcu_din;
                        tgt_strobe <= sel_hot_c;
                    end
                    ST_LOCAL: begin
                        if (cnt == '0) begin
                            cmd <= mcu_din;
                        end
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    mcu_irq_ctrl #(
        .NTGT(NTGT)
    ) u_irq_ctrl (
        .clk       (clk),
        .reset     (reset),
        .status_rd (status_rd_c),
        .mask_wr   (mask_wr_c),
        .mask_din  (mcu_din[NTGT-1:0]),
        .tgt_irq   (tgt_irq),
        .snapshot  (snapshot),
        .tgt_iack  (tgt_iack),
        .mcu_irq   (mcu_irq)
    );

endmodule

// File: tb/tb_mcu_cmd_router.sv
// Directed bench for mcu_cmd_router: forwarding, reply mux, local irq target, aborts, reset.
module tb_mcu_cmd_router;

    localparam int unsigned NTGT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mcu_strobe;
    logic              mcu_start;
    logic [7:0]        mcu_din;
    logic [7:0]        mcu_dout;
    logic              mcu_irq;
    logic [NTGT-1:0]   tgt_strobe;
    logic              tgt_start;
    logic [7:0]        tgt_din;
    logic [8*NTGT-1:0] tgt_dout;
    logic [NTGT-1:0]   tgt_irq;
    logic [NTGT-1:0]   tgt_iack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mcu_cmd_router #(.NTGT(NTGT)) dut (
        .clk        (clk),
        .reset      (reset),
        .mcu_strobe (mcu_strobe),
        .mcu_start  (mcu_start),
        .mcu_din    (mcu_din),
        .mcu_dout   (mcu_dout),
        .mcu_irq    (mcu_irq),
        .tgt_strobe (tgt_strobe),
        .tgt_start  (tgt_start),
        .tgt_din    (tgt_din),
        .tgt_dout   (tgt_dout),
        .tgt_irq    (tgt_irq),
        .tgt_iack   (tgt_iack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; returns on the falling edge after it was sampled.
    task automatic send(input logic start, input logic [7:0] din);
        @(negedge clk);
        mcu_strobe = 1'b1;
        mcu_start  = start;
        mcu_din    = din;
        @(negedge clk);
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
    endtask

    task automatic chk_fwd(input string tag, input logic [3:0] strb, input logic st,
                           input logic [7:0] din);
        chk({tag, "_strobe"}, 32'(tgt_strobe), 32'(strb));
        chk({tag, "_start"},  32'(tgt_start),  32'(st));
        chk({tag, "_din"},    32'(tgt_din),    32'(din));
    endtask

    initial begin
        reset      = 1'b1;
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
        mcu_din    = 8'h00;
        tgt_dout   = 32'h44332211;
        tgt_irq    = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_strobe", 32'(tgt_strobe), 32'h0);
        chk("rst_start",  32'(tgt_start),  32'h0);
        chk("rst_din",    32'(tgt_din),    32'h0);
        chk("rst_iack",   32'(tgt_iack),   32'h0);
        chk("rst_irq",    32'(mcu_irq),    32'h0);
        chk("rst_dout",   32'(mcu_dout),   32'h0);
        reset = 1'b0;

        // Frame [02,01,1C] to target 2
        send(1'b1, 8'h02);
        chk("t2_hdr_strobe", 32'(tgt_strobe), 32'h0);
        chk("t2_dout", 32'(mcu_dout), 32'h22);
        send(1'b0, 8'h01);
        chk_fwd("t2_b1", 4'b0010, 1'b1, 8'h01);
        @(negedge clk);
        chk_fwd("t2_gap", 4'b0000, 1'b0, 8'h01);
        send(1'b0, 8'h1C);
        chk_fwd("t2_b2", 4'b0010, 1'b0, 8'h1C);
        @(negedge clk);
        chk("t2_end_strobe", 32'(tgt_strobe), 32'h0);

        // Reply mux for target 1, then an out-of-range id
        tgt_dout[7:0] = 8'h5C;
        send(1'b1, 8'h01);
        chk("t1_dout_5c", 32'(mcu_dout), 32'h5C);
        send(1'b0, 8'h00);
        chk_fwd("t1_b1", 4'b0001, 1'b1, 8'h00);
        tgt_dout[7:0] = 8'h42;
        #1;
        chk("t1_dout_42", 32'(mcu_dout), 32'h42);
        send(1'b1, 8'h09);
        chk("t9_strobe", 32'(tgt_strobe), 32'h0);
        chk("t9_dout", 32'(mcu_dout), 32'h0);
        send(1'b0, 8'h55);
        chk("t9_b1_strobe", 32'(tgt_strobe), 32'h0);
        chk("t9_b1_dout", 32'(mcu_dout), 32'h0);

        // Aggregated irq and status read with acks
        tgt_irq = 4'b0101;
        #1;
        chk("irq_not_yet", 32'(mcu_irq), 32'h0);
        @(negedge clk);
        chk("irq_set", 32'(mcu_irq), 32'h1);
        send(1'b1, 8'h00);
        chk("loc_dout_pre", 32'(mcu_dout), 32'h0);
        send(1'b0, 8'h00);
        chk("st_iack", 32'(tgt_iack), 32'h5);
        chk("st_dout", 32'(mcu_dout), 32'h05);
        @(negedge clk);
        chk("st_iack_once", 32'(tgt_iack), 32'h0);
        send(1'b0, 8'hAA);
        chk("st_b2_iack", 32'(tgt_iack), 32'h0);
        chk("st_b2_dout", 32'(mcu_dout), 32'h05);

        // Mask write, masked irq ignored
        send(1'b1, 8'h00);
        send(1'b0, 8'h01);
        send(1'b0, 8'h04);
        chk("mask_dout", 32'(mcu_dout), 32'h0);
        tgt_irq = 4'b0001;
        repeat (2) @(negedge clk);
        chk("masked_irq", 32'(mcu_irq), 32'h0);
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        chk("masked_iack", 32'(tgt_iack), 32'h0);
        chk("masked_dout", 32'(mcu_dout), 32'h0);
        tgt_irq = 4'b0000;
        @(negedge clk);

        // Irq rising in the same cycle as the status strobe is captured
        send(1'b1, 8'h00);
        @(negedge clk);
        mcu_strobe = 1'b1;
        mcu_din    = 8'h00;
        tgt_irq    = 4'b0100;
        @(negedge clk);
        mcu_strobe = 1'b0;
        chk("same_cyc_iack", 32'(tgt_iack), 32'h4);
        chk("same_cyc_dout", 32'(mcu_dout), 32'h04);
        chk("unmasked_irq", 32'(mcu_irq), 32'h1);
        tgt_irq = 4'b0000;

        // Frame start mid-FWD aborts and retargets
        send(1'b1, 8'h03);
        send(1'b0, 8'h07);
        chk_fwd("t3_b1", 4'b0100, 1'b1, 8'h07);
        send(1'b0, 8'hAA);
        chk_fwd("t3_b2", 4'b0100, 1'b0, 8'hAA);
        send(1'b1, 8'h01);
        chk("abort_hdr_strobe", 32'(tgt_strobe), 32'h0);
        send(1'b0, 8'h02);
        chk_fwd("t1r_b1", 4'b0001, 1'b1, 8'h02);

        // Reset mid-FWD with a strobe in the reset cycle
        send(1'b1, 8'h02);
        send(1'b0, 8'h33);
        chk("pre_rst_strobe", 32'(tgt_strobe), 32'h2);
        reset      = 1'b1;
        mcu_strobe = 1'b1;
        mcu_din    = 8'h77;
        @(negedge clk);
        mcu_strobe = 1'b0;
        chk("rstmid_strobe", 32'(tgt_strobe), 32'h0);
        chk("rstmid_iack", 32'(tgt_iack), 32'h0);
        reset = 1'b0;
        send(1'b0, 8'h88);
        chk("post_rst_strobe", 32'(tgt_strobe), 32'h0);
        chk("post_rst_dout", 32'(mcu_dout), 32'h0);
        tgt_irq = 4'b0001;
        @(negedge clk);
        chk("mask_restored", 32'(mcu_irq), 32'h1);

        // Long local status frame: counter must saturate, never re-trigger an ack
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        chk("long_iack", 32'(tgt_iack), 32'h1);
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 8'h00);
            chk("long_b_iack", 32'(tgt_iack), 32'h0);
            chk("long_b_dout", 32'(mcu_dout), 32'h01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_cmd_router.md
Name: mcu_cmd_router

Overview:
- Sits between the MCU byte-stream interface (SPI deserialiser) and the MCU-facing peripheral blocks: hid, sd card, osd, sysctrl.
- The first byte of every frame selects a target. The router forwards the remaining bytes to that target, re-flagging the first forwarded byte as the target's command/start byte.
- Muxes the selected target's reply byte back to the MCU.
- Aggregates per-target interrupts into one MCU irq line, with a local status/ack/mask target.

Parameters:
- NTGT, 4, number of forwarded targets (1..7); target ids 1..NTGT map to port index id-1.

Ports:
- clk  in  1  system clock (28 MHz domain)
- reset  in  1  synchronous, active-high
- mcu_strobe  in  1  one-cycle pulse, byte valid
- mcu_start  in  1  qualifies mcu_strobe; byte is first of frame (target id)
- mcu_din  in  8  byte from MCU
- mcu_dout  out  8  reply byte to MCU
- mcu_irq  out  1  aggregated interrupt
- tgt_strobe  out  NTGT  one-hot forwarded strobe
- tgt_start  out  1  shared; forwarded byte is target command byte
- tgt_din  out  8  shared forwarded byte
- tgt_dout  in  8*NTGT  packed reply bytes; index i at [8i+7:8i]
- tgt_irq  in  NTGT  level interrupts from targets
- tgt_iack  out  NTGT  one-cycle ack pulses to targets

Behaviour:
- Reset: state=IDLE, sel=0, tgt_strobe=0, tgt_start=0, tgt_din=0, tgt_iack=0, mcu_irq=0, irq_mask=all ones, snapshot=0.
- States: IDLE, LOCAL, FWD_FIRST, FWD, DISCARD.
- Frame start: any mcu_strobe && mcu_start, in any state, latches sel=mcu_din and aborts the current frame. No byte is forwarded for this strobe. Next state:
  - din=0 → LOCAL (local byte counter cleared)
  - 1 ≤ din ≤ NTGT → FWD_FIRST
  - otherwise → DISCARD
- FWD_FIRST, on mcu_strobe: register tgt_din=mcu_din, tgt_start=1, tgt_strobe[sel-1]=1 for exactly one cycle (latency 1 clk). Then → FWD.
- FWD, on mcu_strobe: same as FWD_FIRST but tgt_start=0. Stay in FWD until the next frame start.
- tgt_strobe, tgt_start and tgt_iack are zero in every cycle without a forwarding/ack event. tgt_din holds its last value.
- DISCARD and IDLE: strobes are ignored; mcu_dout=8'h00.
- mcu_dout is a combinational mux of sel:
  - FWD_FIRST/FWD: tgt_dout[sel-1]
  - LOCAL: local reply register
  - else: 8'h00
- LOCAL protocol, counting strobes after the target byte:
  - Byte 1 = local command.
  - Cmd 8'h00 (irq status): on the byte-1 strobe, snapshot = tgt_irq & irq_mask. The local reply becomes the zero-extended snapshot. tgt_iack = snapshot, pulsed for one cycle. Later bytes return the same snapshot and generate no further acks.
  - Cmd 8'h01 (irq mask): the byte-2 strobe writes irq_mask = mcu_din[NTGT-1:0]. Local reply = 8'h00. Later bytes are ignored.
  - Any other cmd: reply 8'h00, no side effects.
- mcu_irq is registered: mcu_irq <= |(tgt_irq & irq_mask). Latency 1 clk. It follows target levels; the router holds no latched pending state.
- Simultaneous events:
  - An irq rising in the same cycle as the status strobe is included in the snapshot.
  - An irq rising one cycle later is not acked and stays pending.
  - A masked irq is never acked and never reported.
- Reset mid-frame returns to IDLE. No strobe or iack is emitted in the reset cycle or after it, until a new frame start.
- A byte counter saturates at 15. Long frames never wrap.

Decomposition:
- Shared package (mcu_pkg): local target id LOCAL_ID=0, local commands CMD_IRQ_STATUS=8'h00 and CMD_IRQ_MASK=8'h01, a state enum typedef, and the byte-counter width.
- One natural sub-module: mcu_irq_ctrl. It holds the mask register, snapshot, iack pulse generation and mcu_irq register, and is driven by decoded LOCAL strobes from the router FSM.

Test Plan:
- Frame [02,01,1C] → tgt_strobe=0010 twice, one cycle after each mcu_strobe. First with tgt_start=1, tgt_din=01; second with tgt_start=0, tgt_din=1C. No other tgt_strobe bits toggle.
- Frame [01,00,xx,xx] with tgt_dout[0] driven 5C then 42 → mcu_dout shows 5C then 42 while sel=1. Then frame [09,..] → no strobes, mcu_dout=00.
- tgt_irq=0101, mask=1111 → mcu_irq=1 one clk later. Frame [00,00] → mcu_dout=05, tgt_iack=0101 pulsed exactly one cycle.
- Frame [00,01,04] sets mask=0100. tgt_irq=0001 → mcu_irq=0, and a status read returns 00 with no iack. tgt_irq=0100 → mcu_irq=1.
- Frame start in mid-FWD: [03,07,aa,(start)01,02] → target 3 gets 07,aa. Target 1 gets 02 with tgt_start=1. Reset asserted mid-FWD → no further strobes, mask returns to 1111.
